hoplite_client: RTL and testbench

PE-side network interface for the Hoplite deflection-routed torus; it pairs one-to-one with a switch at (X_POS, Y_POS). It buffers outbound packets from the PE and presents them to the switch's PE-injection port, holding each one until the switch accepts it. It also captures packets the switch ejects to the PE into a receive queue; the network cannot be back-pressured, so packets that arrive when that queue is full are dropped and reported.

---
 rtl/hoplite_pkg.sv | 11 +
 rtl/hoplite_sync_fifo.sv | 37 +++
 rtl/hoplite_client.sv | 84 ++++++++
 tb/tb_hoplite_client.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hoplite_pkg.sv
// hoplite_pkg: packet field positions and default widths shared with the Hoplite switch
package hoplite_pkg;
  localparam int P_W_DEF = 32;
  localparam int X_AW_DEF = 2;
  localparam int Y_AW_DEF = 2;
  localparam int ADDRX_LSB = 0;
  localparam int ADDRX_MSB = ADDRX_LSB + X_AW_DEF - 1;
  localparam int ADDRY_LSB = ADDRX_MSB + 1;
  localparam int ADDRY_MSB = ADDRY_LSB + Y_AW_DEF - 1;
  typedef logic [P_W_DEF-1:0] pkt_t;
endpackage

// File: rtl/hoplite_sync_fifo.sv
// hoplite_sync_fifo: power-of-two synchronous FIFO with MSB-wrap pointers and a combinational head
module hoplite_sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  always_comb begin
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
  end
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = wp_q == rp_q;
  assign head  = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/hoplite_client.sv
// hoplite_client: PE network interface for a Hoplite torus switch; injection and ejection queues.
// Define HOPLITE_CLIENT_STATS_EN to add saturating stall/drop counters.
module hoplite_client
  import hoplite_pkg::*;
#(
  parameter int P_W = P_W_DEF,
  parameter int X_AW = X_AW_DEF,
  parameter int Y_AW = Y_AW_DEF,
  parameter int X_POS = 0,
  parameter int Y_POS = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [P_W-1:0] tx_pkt,
  input  logic           tx_vld,
  output logic           tx_rdy,
  output logic [P_W-1:0] rx_pkt,
  output logic           rx_vld,
  input  logic           rx_rdy,
  output logic [P_W-1:0] pein_pkt,
  output logic           pein_vld,
  input  logic           peout_rdy,
  input  logic [P_W-1:0] noc_pkt,
  input  logic           noc_vld,
  output logic           rx_drop
`ifdef HOPLITE_CLIENT_STATS_EN
  ,
  output logic [CNT_W-1:0] inj_stall_cnt,
  output logic [CNT_W-1:0] rx_drop_cnt
`endif
);
  if (X_POS >= (1 << X_AW) || Y_POS >= (1 << Y_AW) || P_W <= ADDRY_MSB || CNT_W < 1 ||
      ADDRX_MSB - ADDRX_LSB + 1 != X_AW || ADDRY_MSB - ADDRY_LSB + 1 != Y_AW) begin : g_bad_cfg
    $error("hoplite_client: switch position or field widths inconsistent with hoplite_pkg");
  end
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [P_W-1:0] tx_head, rx_head;
  logic drop_q, drop_d;
  hoplite_sync_fifo #(.W(P_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(tx_pkt),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );
  hoplite_sync_fifo #(.W(P_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(noc_pkt),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );
  // pein_vld comes only from queue state; the switch's peout_rdy is derived from it
  always_comb begin
    tx_rdy   = !rst && !tx_full;
    tx_push  = tx_vld && tx_rdy;
    pein_vld = !tx_empty;
    pein_pkt = tx_empty ? '0 : tx_head;
    tx_pop   = pein_vld && peout_rdy;
    rx_vld   = !rx_empty;
    rx_pkt   = rx_empty ? '0 : rx_head;
    rx_pop   = rx_vld && rx_rdy;
    rx_push  = noc_vld && (!rx_full || rx_pop);
    drop_d   = noc_vld && rx_full && !rx_pop;
  end
  assign rx_drop = drop_q;
  always_ff @(posedge clk) drop_q <= rst ? 1'b0 : drop_d;
`ifdef HOPLITE_CLIENT_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, drop_cnt_q, drop_cnt_d;
  always_comb begin
    stall_cnt_d = (pein_vld && !peout_rdy && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    drop_cnt_d  = (drop_d && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
  assign inj_stall_cnt = stall_cnt_q;
  assign rx_drop_cnt   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_hoplite_client.sv
// tb_hoplite_client: directed self-checking bench for hoplite_client (TX/RX queues, drops, reset, stats)
module tb_hoplite_client;
  localparam int P_W = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [P_W-1:0] tx_pkt = '0, noc_pkt = '0;
  logic tx_vld = 1'b0, rx_rdy = 1'b0, peout_rdy = 1'b0, noc_vld = 1'b0;
  logic tx_rdy, rx_vld, pein_vld, rx_drop;
  logic [P_W-1:0] rx_pkt, pein_pkt;
`ifdef HOPLITE_CLIENT_STATS_EN
  logic [CNT_W-1:0] inj_stall_cnt, rx_drop_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  hoplite_client #(
    .P_W(P_W), .X_AW(2), .Y_AW(2), .X_POS(0), .Y_POS(0),
    .TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tx_pkt(tx_pkt), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .rx_pkt(rx_pkt), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .pein_pkt(pein_pkt), .pein_vld(pein_vld), .peout_rdy(peout_rdy),
    .noc_pkt(noc_pkt), .noc_vld(noc_vld), .rx_drop(rx_drop)
`ifdef HOPLITE_CLIENT_STATS_EN
    , .inj_stall_cnt(inj_stall_cnt), .rx_drop_cnt(rx_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_rdy: got %0h expected 0", tx_rdy); end
    n_chk++; if (pein_vld !== 1'b0) begin n_fail++; $display("FAIL reset_pein_vld: got %0h expected 0", pein_vld); end
    n_chk++; if (rx_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rx_vld: got %0h expected 0", rx_vld); end
    n_chk++; if (rx_drop !== 1'b0) begin n_fail++; $display("FAIL reset_rx_drop: got %0h expected 0", rx_drop); end
    n_chk++; if (pein_pkt !== 32'h0) begin n_fail++; $display("FAIL reset_pein_pkt: got %0h expected 0", pein_pkt); end
    n_chk++; if (rx_pkt !== 32'h0) begin n_fail++; $display("FAIL reset_rx_pkt: got %0h expected 0", rx_pkt); end
`ifdef HOPLITE_CLIENT_STATS_EN
    n_chk++; if (inj_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", inj_stall_cnt); end
    n_chk++; if (rx_drop_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", rx_drop_cnt); end
`endif
    rst = 1'b0;
    #1;
    n_chk++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx_rdy: got %0h expected 1", tx_rdy); end
    tick();
  endtask

  task automatic test_single_tx();
    peout_rdy = 1'b1;
    tx_pkt = 32'h0000_0123;
    tx_vld = 1'b1;
    #1;
    n_chk++; if (pein_vld !== 1'b0) begin n_fail++; $display("FAIL single_pre_vld: got %0h expected 0", pein_vld); end
    tick();
    tx_vld = 1'b0;
    n_chk++; if (pein_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %0h expected 1", pein_vld); end
    n_chk++; if (pein_pkt !== 32'h0000_0123) begin n_fail++; $display("FAIL single_pkt: got %0h expected 123", pein_pkt); end
    tick();
    n_chk++; if (pein_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld_drop: got %0h expected 0", pein_vld); end
  endtask

  task automatic test_stall();
    logic [P_W-1:0] pk [4];
    pk[0] = 32'hAAAA_0001; pk[1] = 32'hBBBB_0002; pk[2] = 32'hCCCC_0003; pk[3] = 32'hDDDD_0004;
    peout_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_pkt = pk[i];
      tx_vld = 1'b1;
      tick();
    end
    tx_vld = 1'b0;
    #1;
    n_chk++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_tx_rdy_full: got %0h expected 0", tx_rdy); end
    n_chk++; if (pein_pkt !== pk[0]) begin n_fail++; $display("FAIL stall_head: got %0h expected %0h", pein_pkt, pk[0]); end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_chk++; if (pein_pkt !== pk[0] || pein_vld !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0h/%0h expected %0h/1", i, pein_pkt, pein_vld, pk[0]); end
    end
`ifdef HOPLITE_CLIENT_STATS_EN
    n_chk++; if (inj_stall_cnt !== 4'd10) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 10", inj_stall_cnt); end
`endif
    peout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (pein_pkt !== pk[i] || pein_vld !== 1'b1) begin n_fail++; $display("FAIL stall_release[%0d]: got %0h expected %0h", i, pein_pkt, pk[i]); end
      tick();
    end
    n_chk++; if (pein_vld !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %0h expected 0", pein_vld); end
    n_chk++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL stall_tx_rdy_back: got %0h expected 1", tx_rdy); end
  endtask

  task automatic test_rx_overflow();
    int drops;
    drops = 0;
    rx_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      noc_pkt = P_W'(i);
      noc_vld = 1'b1;
      tick();
      drops += int'(rx_drop);
      n_chk++; if (rx_drop !== (i >= 5)) begin n_fail++; $display("FAIL ovf_drop[%0d]: got %0h expected %0h", i, rx_drop, (i >= 5)); end
      if (i == 1) begin
        n_chk++; if (rx_vld !== 1'b1 || rx_pkt !== 32'd1) begin n_fail++; $display("FAIL ovf_latency: got %0h/%0h expected 1/1", rx_vld, rx_pkt); end
      end
    end
    noc_vld = 1'b0;
    tick();
    n_chk++; if (rx_drop !== 1'b0) begin n_fail++; $display("FAIL ovf_drop_end: got %0h expected 0", rx_drop); end
    n_chk++; if (drops !== 2) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 2", drops); end
`ifdef HOPLITE_CLIENT_STATS_EN
    n_chk++; if (rx_drop_cnt !== 4'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 2", rx_drop_cnt); end
`endif
    rx_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_chk++; if (rx_pkt !== P_W'(i) || rx_vld !== 1'b1) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %0h expected %0h", i, rx_pkt, i); end
      tick();
    end
    rx_rdy = 1'b0;
    n_chk++; if (rx_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %0h expected 0", rx_vld); end
  endtask

  task automatic test_rx_concurrent();
    rx_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      noc_pkt = 32'h11 + P_W'(i);
      noc_vld = 1'b1;
      tick();
    end
    noc_pkt = 32'h15;
    rx_rdy = 1'b1;
    #1;
    n_chk++; if (rx_pkt !== 32'h11) begin n_fail++; $display("FAIL conc_head: got %0h expected 11", rx_pkt); end
    tick();
    noc_vld = 1'b0;
    rx_rdy = 1'b0;
    n_chk++; if (rx_drop !== 1'b0) begin n_fail++; $display("FAIL conc_no_drop: got %0h expected 0", rx_drop); end
    tick();
    n_chk++; if (rx_vld !== 1'b1) begin n_fail++; $display("FAIL conc_vld: got %0h expected 1", rx_vld); end
`ifdef HOPLITE_CLIENT_STATS_EN
    n_chk++; if (rx_drop_cnt !== 4'd2) begin n_fail++; $display("FAIL conc_drop_cnt: got %0d expected 2", rx_drop_cnt); end
`endif
    rx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (rx_pkt !== 32'h12 + P_W'(i) || rx_vld !== 1'b1) begin n_fail++; $display("FAIL conc_drain[%0d]: got %0h expected %0h", i, rx_pkt, 32'h12 + i); end
      tick();
    end
    rx_rdy = 1'b0;
    n_chk++; if (rx_vld !== 1'b0) begin n_fail++; $display("FAIL conc_occupancy: got %0h expected 0", rx_vld); end
  endtask

  task automatic test_back_to_back();
    logic [P_W-1:0] pk [6];
    pk[0] = 32'h0000_1000; pk[1] = 32'hDEAD_BEE5; pk[2] = 32'h1234_567A;
    pk[3] = 32'h0F0F_F0F0; pk[4] = 32'hFFFF_FFFF; pk[5] = 32'h8000_0003;
    peout_rdy = 1'b1;
    rx_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_pkt = pk[i];
      tx_vld = 1'b1;
      noc_pkt = pk[i] ^ 32'h0000_FFFF;
      noc_vld = 1'b1;
      tick();
      n_chk++; if (pein_pkt !== pk[i] || pein_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_tx[%0d]: got %0h expected %0h", i, pein_pkt, pk[i]); end
      n_chk++; if (rx_pkt !== (pk[i] ^ 32'h0000_FFFF) || rx_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %0h expected %0h", i, rx_pkt, pk[i] ^ 32'h0000_FFFF); end
      n_chk++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_rdy[%0d]: got %0h expected 1", i, tx_rdy); end
    end
    tx_vld = 1'b0;
    noc_vld = 1'b0;
    tick();
    rx_rdy = 1'b0;
    n_chk++; if (pein_vld !== 1'b0 || rx_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h/%0h expected 0/0", pein_vld, rx_vld); end
  endtask

`ifdef HOPLITE_CLIENT_STATS_EN
  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peout_rdy = 1'b0;
    tx_pkt = 32'h5A5A_0000;
    tx_vld = 1'b1;
    tick();
    tx_vld = 1'b0;
    repeat (20) tick();
    n_chk++; if (inj_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d expected 15", inj_stall_cnt); end
    peout_rdy = 1'b1;
    tick();
    n_chk++; if (pein_vld !== 1'b0 || inj_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0h/%0d expected 0/15", pein_vld, inj_stall_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    peout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_pkt = 32'hA1 + P_W'(i);
      tx_vld = 1'b1;
      tick();
    end
    tx_vld = 1'b0;
    n_chk++; if (pein_vld !== 1'b1 || pein_pkt !== 32'hA1) begin n_fail++; $display("FAIL mid_pre: got %0h/%0h expected 1/a1", pein_vld, pein_pkt); end
    rst = 1'b1;
    tick();
    n_chk++; if (pein_vld !== 1'b0) begin n_fail++; $display("FAIL mid_pein_vld: got %0h expected 0", pein_vld); end
    n_chk++; if (pein_pkt !== 32'h0) begin n_fail++; $display("FAIL mid_pein_pkt: got %0h expected 0", pein_pkt); end
    n_chk++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_tx_rdy_rst: got %0h expected 0", tx_rdy); end
    rst = 1'b0;
    tick();
    n_chk++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_tx_rdy: got %0h expected 1", tx_rdy); end
    peout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (pein_vld !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %0h/%0h expected 0", i, pein_vld, pein_pkt); end
    end
`ifdef HOPLITE_CLIENT_STATS_EN
    n_chk++; if (inj_stall_cnt !== 4'd0 || rx_drop_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d/%0d expected 0/0", inj_stall_cnt, rx_drop_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_stall();
    test_rx_overflow();
    test_rx_concurrent();
    test_back_to_back();
`ifdef HOPLITE_CLIENT_STATS_EN
    test_saturation();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
